// File: rtl/ws281x_frame_ctrl.sv
// Pixel-buffer feeder for the WS281x line driver: streams a frame in GRB order over go/valid/last/ack.
// Optional per-channel brightness scaling is compiled in with `define WS281X_BRIGHTNESS_EN.
`timescale 1ns/1ps
module ws281x_frame_ctrl #(
  parameter int unsigned NumLeds = 32,
  parameter int unsigned AddrW   = (NumLeds > 1) ? $clog2(NumLeds) : 1,
  parameter int unsigned LenW    = $clog2(NumLeds + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [23:0]      wr_data_i,
  input  logic [LenW-1:0]  frame_len_i,
  input  logic [7:0]       brightness_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             drv_go_o,
  output logic [23:0]      drv_data_o,
  output logic             drv_data_valid_o,
  output logic             drv_data_last_o,
  input  logic             drv_data_ack_i,
  input  logic             drv_idle_i
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_PRESENT  = 2'd2,
    ST_WAIT_END = 2'd3
  } state_e;

  state_e           state_r, state_s;
  logic [23:0]      mem_r [NumLeds];
  logic [AddrW-1:0] ptr_r;
  logic [LenW-1:0]  len_r;
  logic [7:0]       bright_r;
  logic             first_r, first_s;
  logic [23:0]      pix_r;
  logic             last_r;
  logic             busy_r, done_r, go_r, valid_r;
  logic             latch_s, fetch_s, ack_s, done_s;
  logic             addr_ok_s, is_last_s;
  logic [LenW-1:0]  len_clip_s;
  logic [23:0]      raw_s, fetch_pix_s;

  function automatic logic [23:0] reorder_grb(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

  // Power-of-two depths accept every address; otherwise the top of the range is dropped.
  if (NumLeds == (32'd1 << AddrW)) begin : gen_addr_full
    assign addr_ok_s = 1'b1;
  end else begin : gen_addr_cmp
    assign addr_ok_s = (wr_addr_i < AddrW'(NumLeds));
  end

  assign len_clip_s = (frame_len_i > LenW'(NumLeds)) ? LenW'(NumLeds) : frame_len_i;
  assign is_last_s  = (LenW'(ptr_r) == (len_r - LenW'(1'b1)));
  assign raw_s      = mem_r[ptr_r];

`ifdef WS281X_BRIGHTNESS_EN
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(c) * 16'({1'b0, b} + 9'd1);
    return 8'(prod >> 8);
  endfunction

  assign fetch_pix_s = {scale_ch(raw_s[15:8], bright_r),
                        scale_ch(raw_s[23:16], bright_r),
                        scale_ch(raw_s[7:0], bright_r)};
`else
  logic unused_bright_s;
  assign unused_bright_s = ^bright_r;
  assign fetch_pix_s     = reorder_grb(raw_s);
`endif

  // Frame sequencer: next state and single-cycle events.
  always_comb begin
    state_s = state_r;
    latch_s = 1'b0;
    fetch_s = 1'b0;
    ack_s   = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i && (frame_len_i != {LenW{1'b0}})) begin
          latch_s = 1'b1;
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        fetch_s = 1'b1;
        state_s = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (drv_data_ack_i) begin
          ack_s   = 1'b1;
          state_s = last_r ? ST_WAIT_END : ST_FETCH;
        end else begin
          state_s = ST_PRESENT;
        end
      end
      ST_WAIT_END: begin
        if (drv_idle_i) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_END;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // First-pixel flag: raised at frame start, dropped on the first ack.
  always_comb begin
    first_s = first_r;
    if (latch_s) begin
      first_s = 1'b1;
    end else if (ack_s) begin
      first_s = 1'b0;
    end else begin
      first_s = first_r;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Pixel buffer; a write racing a fetch of the same entry lands after the fetch samples it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumLeds; i++) begin
        mem_r[i] <= 24'h000000;
      end
    end else if (wr_en_i && addr_ok_s) begin
      mem_r[wr_addr_i] <= wr_data_i;
    end
  end

  // Frame context, pixel staging and registered driver-side outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_r    <= {AddrW{1'b0}};
      len_r    <= {LenW{1'b0}};
      bright_r <= 8'h00;
      first_r  <= 1'b0;
      pix_r    <= 24'h000000;
      last_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      go_r     <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      if (latch_s) begin
        len_r    <= len_clip_s;
        bright_r <= brightness_i;
        ptr_r    <= {AddrW{1'b0}};
      end else if (ack_s && !last_r) begin
        ptr_r <= ptr_r + AddrW'(1'b1);
      end
      first_r <= first_s;
      if (fetch_s) begin
        pix_r  <= fetch_pix_s;
        last_r <= is_last_s;
      end else if (state_s != ST_PRESENT) begin
        last_r <= 1'b0;
      end
      busy_r  <= (state_s != ST_IDLE);
      valid_r <= (state_s == ST_PRESENT);
      go_r    <= (state_s == ST_PRESENT) && first_s;
      done_r  <= done_s;
    end
  end

  assign busy_o           = busy_r;
  assign done_o           = done_r;
  assign drv_go_o         = go_r;
  assign drv_data_o       = pix_r;
  assign drv_data_valid_o = valid_r;
  assign drv_data_last_o  = last_r;

endmodule

// File: tb/tb_ws281x_frame_ctrl.sv
// Directed bench for ws281x_frame_ctrl with a simple acking driver model (NumLeds = 32).
`timescale 1ns/1ps
module tb_ws281x_frame_ctrl;

  logic        clk, rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [23:0] wr_data;
  logic [5:0]  frame_len;
  logic [7:0]  brightness;
  logic        start, ack, idle;
  logic        busy, done, go, valid, last;
  logic [23:0] data;

  int total = 0;
  int bad   = 0;

  logic [23:0] got_q[$];
  bit          go_q[$];
  bit          lst_q[$];

  ws281x_frame_ctrl #(.NumLeds(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .frame_len_i(frame_len), .brightness_i(brightness), .start_i(start),
    .busy_o(busy), .done_o(done), .drv_go_o(go), .drv_data_o(data),
    .drv_data_valid_o(valid), .drv_data_last_o(last),
    .drv_data_ack_i(ack), .drv_idle_i(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_frame(input logic [5:0] len, input logic [7:0] bri);
    frame_len = len; brightness = bri; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Driver model: acks each presented pixel; optional write/start injected at a given cycle.
  task automatic drive(input int budget, input int wr_cyc, input logic [4:0] wa,
                       input logic [23:0] wd, input int st_cyc,
                       output bit fin, output int first_cyc);
    int cyc = 0;
    fin = 1'b0; first_cyc = -1;
    got_q.delete(); go_q.delete(); lst_q.delete();
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      ack = 1'b0; wr_en = 1'b0; start = 1'b0;
      if (cyc == wr_cyc) begin
        wr_en = 1'b1; wr_addr = wa; wr_data = wd;
      end
      if (cyc == st_cyc) start = 1'b1;
      if (valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        got_q.push_back(data); go_q.push_back(go); lst_q.push_back(last);
        if (go) idle = 1'b0;
        ack = 1'b1;
        if (last) fin = 1'b1;
      end
    end
    @(negedge clk);
    ack = 1'b0; wr_en = 1'b0; start = 1'b0;
  endtask

  task automatic end_frame(input string tag);
    chk({tag, "_wait_busy"}, 32'(busy), 32'd1);
    chk({tag, "_wait_nodone"}, 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    chk({tag, "_gap_nodone"}, 32'(done), 32'd0);
    idle = 1'b1;
    @(negedge clk);
    chk({tag, "_done_hi"}, 32'({done, busy}), 32'b10);
    @(negedge clk);
    chk({tag, "_done_lo"}, 32'(done), 32'd0);
  endtask

  initial begin
    bit fin;
    int fc, errs, nlast;
    logic [23:0] exp_w;

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 24'h0;
    frame_len = 6'd0; brightness = 8'd255; start = 1'b0; ack = 1'b0; idle = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ctl", 32'({busy, done, go, valid, last}), 32'd0);
    chk("reset_data", 32'(data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Three-pixel frame with reorder, go on first, last on third.
    wr(5'd0, 24'h112233); wr(5'd1, 24'h445566); wr(5'd2, 24'h778899);
    start_frame(6'd3, 8'd255);
    chk("lat_busy_valid", 32'({busy, valid}), 32'b10);
    drive(20, -1, 5'd0, 24'h0, -1, fin, fc);
    chk("f3_fin", 32'(fin), 32'd1);
    chk("f3_latency", 32'(fc), 32'd1);
    chk("f3_count", 32'(got_q.size()), 32'd3);
    chk("f3_w0", 32'(got_q[0]), 32'h221133);
    chk("f3_w1", 32'(got_q[1]), 32'h554466);
    chk("f3_w2", 32'(got_q[2]), 32'h887799);
    chk("f3_go", 32'({go_q[0], go_q[1], go_q[2]}), 32'b100);
    chk("f3_last", 32'({lst_q[0], lst_q[1], lst_q[2]}), 32'b001);
    end_frame("f3");

    // Zero-length start is ignored.
    start_frame(6'd0, 8'd255);
    for (int i = 0; i < 4; i++) begin
      chk("len0_quiet", 32'({busy, valid, go, done}), 32'd0);
      @(negedge clk);
    end

    // Length 40 clips to 32; a start mid-frame is ignored.
    for (int i = 0; i < 32; i++) wr(5'(i), {8'(i), 8'(8'hA0 + i), 8'(8'h50 + i)});
    start_frame(6'd40, 8'd255);
    frame_len = 6'd2;
    drive(200, -1, 5'd0, 24'h0, 10, fin, fc);
    chk("f32_fin", 32'(fin), 32'd1);
    chk("f32_count", 32'(got_q.size()), 32'd32);
    errs = 0; nlast = 0;
    for (int i = 0; i < got_q.size(); i++) begin
      exp_w = {8'(8'hA0 + i), 8'(i), 8'(8'h50 + i)};
      if (got_q[i] !== exp_w) errs++;
      if (lst_q[i]) nlast++;
    end
    chk("f32_word_errs", 32'(errs), 32'd0);
    chk("f32_last_count", 32'(nlast), 32'd1);
    chk("f32_last_pos", 32'(lst_q[31]), 32'd1);
    end_frame("f32");

    // Write to pixel 1 while pixel 0 is presented: new value is sent.
    wr(5'd0, 24'h123456); wr(5'd1, 24'h000000);
    start_frame(6'd2, 8'd255);
    drive(20, 1, 5'd1, 24'hFFFFFF, -1, fin, fc);
    chk("wr_live_count", 32'(got_q.size()), 32'd2);
    chk("wr_live_w0", 32'(got_q[0]), 32'h341256);
    chk("wr_live_w1", 32'(got_q[1]), 32'hFFFFFF);
    end_frame("wr_live");

    // Write colliding with the fetch of the same entry: fetch sees the old value.
    start_frame(6'd2, 8'd255);
    drive(20, 2, 5'd1, 24'h0A0B0C, -1, fin, fc);
    chk("wr_race_w1", 32'(got_q[1]), 32'hFFFFFF);
    end_frame("wr_race");
    start_frame(6'd2, 8'd255);
    drive(20, -1, 5'd0, 24'h0, -1, fin, fc);
    chk("wr_after_w1", 32'(got_q[1]), 32'h0B0A0C);
    end_frame("wr_after");

    // One-LED frame with brightness 127.
    wr(5'd0, 24'hFF8001);
    start_frame(6'd1, 8'd127);
    drive(20, -1, 5'd0, 24'h0, -1, fin, fc);
`ifdef WS281X_BRIGHTNESS_EN
    exp_w = 24'h407F00;
`else
    exp_w = 24'h80FF01;
`endif
    chk("one_count", 32'(got_q.size()), 32'd1);
    chk("one_word", 32'(got_q[0]), 32'(exp_w));
    chk("one_go_last", 32'({go_q[0], lst_q[0]}), 32'b11);
    end_frame("one");

    // Asynchronous reset during PRESENT, then the buffer reads back as zeros.
    wr(5'd0, 24'hABCDEF); wr(5'd1, 24'h123456);
    start_frame(6'd2, 8'd255);
    @(negedge clk);
    chk("rst_pre_valid", 32'(valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", 32'({busy, done, go, valid, last}), 32'd0);
    chk("rst_async_data", 32'(data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_frame(6'd2, 8'd255);
    drive(20, -1, 5'd0, 24'h0, -1, fin, fc);
    chk("rst_after_count", 32'(got_q.size()), 32'd2);
    chk("rst_after_words", 32'({got_q[0], got_q[1]} != 48'd0), 32'd0);
    end_frame("rst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ws281x_frame_ctrl.md
Name: ws281x_frame_ctrl

Overview:
- Upstream feeder for the WS281x serial line driver.
- Holds a pixel buffer written by a simple register-style write port.
- On a start pulse, streams N pixels to the driver over its go/valid/last/ack handshake, reordering RGB to the LED's GRB wire order.
- Reports busy/done to software-facing control logic.

Parameters:
- NumLeds, 32: pixel buffer depth; maximum LEDs per frame (1..256).
- AddrW, $clog2(NumLeds): pixel write address width (localparam-derived; do not override).
- LenW, $clog2(NumLeds+1): frame length width (localparam-derived).

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- wr_en_i  in  1  pixel write strobe
- wr_addr_i  in  AddrW  pixel index
- wr_data_i  in  24  {R[23:16], G[15:8], B[7:0]}
- frame_len_i  in  LenW  LEDs in the next frame, sampled at start
- brightness_i  in  8  global brightness, sampled at start; only used with the optional feature
- start_i  in  1  frame start pulse
- busy_o  out  1  frame in progress
- done_o  out  1  one-cycle pulse at frame completion
- drv_go_o  out  1  to driver go input
- drv_data_o  out  24  to driver data, GRB, MSB sent first
- drv_data_valid_o  out  1  to driver data-valid
- drv_data_last_o  out  1  to driver data-last
- drv_data_ack_i  in  1  from driver data-ack (combinational in the driver)
- drv_idle_i  in  1  from driver idle

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous, active-low.
- Reset values:
  - State IDLE; all outputs 0.
  - Pixel buffer all zero; read pointer 0.
  - Latched length and brightness 0.
- Write port:
  - On wr_en_i with wr_addr_i < NumLeds, the buffer entry updates next edge.
  - Writes to addresses >= NumLeds are dropped.
  - Writes are accepted in every state.
  - A write in the same cycle as a FETCH of the same entry: FETCH captures the old value.
- Colour reorder: drv_data_o = {G, R, B} of the stored entry.
- FSM states:
  - IDLE:
    - start_i with frame_len_i != 0: latch len = min(frame_len_i, NumLeds), latch brightness, ptr = 0, first flag = 1, go FETCH.
    - start_i with frame_len_i == 0 is ignored; no done_o.
  - FETCH (1 cycle): pix_q <= reorder(mem[ptr]); last_q <= (ptr == len-1); go PRESENT.
  - PRESENT:
    - drv_data_valid_o = 1; drv_data_o = pix_q; drv_data_last_o = last_q.
    - drv_go_o = first flag (the driver ignores go outside its idle state).
    - On drv_data_ack_i: clear first flag. If last_q, go WAIT_END; else ptr++ and go FETCH.
  - WAIT_END:
    - Wait for drv_idle_i == 1, i.e. the driver has finished its reset gap.
    - Then go IDLE, assert done_o for exactly 1 cycle on that transition.
- Outputs and timing:
  - busy_o = (state != IDLE).
  - drv_data_valid_o and drv_go_o are 0 outside PRESENT.
  - Latency start_i -> first drv_data_valid_o = 2 cycles.
  - Next pixel is ready 2 cycles after ack, well inside one 24-bit pixel time, so the driver never stalls between pixels.
- Boundary cases:
  - start_i while busy is ignored.
  - A 1-LED frame presents go+valid+last together.
  - Reset mid-frame aborts immediately: outputs go low, buffer clears.
  - The driver completes or holds the line low independently.

Optional Feature:
- Macro WS281X_BRIGHTNESS_EN.
- Defined: each 8-bit channel c is scaled at FETCH to (c * (b+1)) >> 8, where b is the latched brightness. b = 255 is identity; b = 0 gives floor(c/256) = 0.
- Not defined: brightness_i is unused and channels pass through unmodified; no multipliers are instantiated.

Test Plan:
- Write addr 0..2 with 0x112233, 0x445566, 0x778899; len 3; start; driver model acks.
  -> Words 0x221133, 0x554466, 0x887799 in order; go only on the first; last only on the third; done_o 1 cycle after drv_idle_i returns.
- len 0 start -> busy_o stays 0, no go/valid, no done_o.
- len 40 with NumLeds = 32 -> exactly 32 acks; last on pixel 31.
- start_i pulsed mid-frame -> ignored; pixel count unchanged.
- Write addr 1 = 0xFFFFFF while pixel 0 is transmitting in a 2-LED frame -> pixel 1 sent as 0xFFFFFF. Write addr 40 -> no buffer change.
- With WS281X_BRIGHTNESS_EN, brightness 127, pixel 0xFF8001 -> 0x407F00 (G=0x40, R=0x7F, B=0x00). Without the macro -> 0x80FF01.
- Assert rst_ni low during PRESENT -> all outputs 0 asynchronously; next frame reads zeros.
